// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// A multiply uses shift-add over a 2*XLEN product. A divide uses restoring
// division and produces one quotient bit per cycle. Signed operands are
// converted to magnitudes in LOAD, and the recorded sign is applied in FIX.
// Optional feature: define MULDIV_FAST_MUL_EN to form multiply products in a
// single combinational step in LOAD. Divide latency is unchanged.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] valA,
  input  logic [XLEN-1:0] valB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] resultado
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   dvs_q;     // |rs2|: multiplicand or divisor
  logic [2*XLEN-1:0] acc_q;     // mul: {hi, lo} product; div: {remainder, quotient}
  logic              neg_q;
  logic [CW-1:0]     counter;

  logic              is_div;
  logic              a_sgn;
  logic              b_sgn;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              neg_res;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN-1:0]   special_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_res;

  // Operand decode, special-case detection, per-step datapath and final sign fix-up.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    is_div      = op_q[2];
    a_sgn       = 1'b0;
    b_sgn       = 1'b0;
    special_res = '0;
    fix_res     = '0;

    if (is_div) begin
      a_sgn = ~op_q[0];
      b_sgn = ~op_q[0];
    end else begin
      a_sgn = (op_q == 3'b001) || (op_q == 3'b010);
      b_sgn = (op_q == 3'b001);
    end

    a_neg = a_sgn & a_q[XLEN-1];
    b_neg = b_sgn & b_q[XLEN-1];
    mag_a = a_neg ? -a_q : a_q;
    mag_b = b_neg ? -b_q : b_q;

    // The remainder takes the sign of the dividend. The quotient and product take the XOR of the operand signs.
    if (is_div && op_q[1]) neg_res = a_neg;
    else                   neg_res = a_neg ^ b_neg;

    div_zero = is_div && (b_q == '0);
    div_ovf  = is_div && !op_q[0] && (a_q == MIN_NEG) && (b_q == '1);

    if (div_zero) special_res = op_q[1] ? a_q : '1;
    else          special_res = op_q[1] ? '0  : MIN_NEG;

    // One shift-add step: add the multiplicand into the high half when the LSB is set, then shift right.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // One restoring step: shift the next dividend bit into the remainder and subtract when it fits.
    div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, dvs_q};
    if (div_diff[XLEN]) div_next = {acc_q[2*XLEN-2:0], 1'b0};
    else                div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    if (is_div)               fix_res = op_q[1] ? rem_fix : quo_fix;
    else if (op_q == 3'b000)  fix_res = prod_fix[XLEN-1:0];
    else                      fix_res = prod_fix[2*XLEN-1:XLEN];
  end

  // Control FSM with registered busy/done/resultado and the iterative datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      dvs_q     <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      counter   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      resultado <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= funct3;
            a_q   <= valA;
            b_q   <= valB;
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end

        S_LOAD: begin
          neg_q <= neg_res;
          dvs_q <= mag_b;
          if (div_zero || div_ovf) begin
            resultado <= special_res;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!is_div) begin
            acc_q <= {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
            state <= S_FIX;
`endif
          end else begin
            acc_q   <= {{XLEN{1'b0}}, mag_a};
            counter <= CW'(XLEN - 1);
            state   <= S_RUN;
          end
        end

        S_RUN: begin
          acc_q <= is_div ? div_next : mul_next;
          if (counter == '0) state <= S_FIX;
          else               counter <= counter - 1'b1;
        end

        S_FIX: begin
          resultado <= fix_res;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= S_DONE;
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
